// File: rtl/cpu_pkg.sv
// Shared core definitions: ARM condition codes, major instruction classes, branch field
// helpers and the fetch queue entry layout.
package cpu_pkg;

  localparam int INST_W = 32;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  // Instruction class as encoded in bits [27:25].
  typedef enum logic [2:0] {
    INST_TYPE_DP_REG = 3'b000,
    INST_TYPE_DP_IMM = 3'b001,
    INST_TYPE_LS_IMM = 3'b010,
    INST_TYPE_LS_REG = 3'b011,
    INST_TYPE_LSM    = 3'b100,
    INST_TYPE_BRANCH = 3'b101,
    INST_TYPE_COPROC = 3'b110,
    INST_TYPE_SWI    = 3'b111
  } inst_type_e;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] word;
    logic              pred_taken;
  } fq_entry_t;

  function automatic cond_e get_cond(input logic [INST_W-1:0] w);
    return cond_e'(w[31:28]);
  endfunction

  function automatic inst_type_e get_inst_type(input logic [INST_W-1:0] w);
    return inst_type_e'(w[27:25]);
  endfunction

  // Byte offset of a B/BL: sign-extended imm24 scaled to words.
  function automatic logic [INST_W-1:0] branch_offset(input logic [INST_W-1:0] w);
    return {{6{w[23]}}, w[23:0], 2'b00};
  endfunction

  function automatic logic is_uncond_branch(input logic [INST_W-1:0] w);
    return (get_cond(w) == COND_AL) && (get_inst_type(w) == INST_TYPE_BRANCH);
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-to-decode instruction handshake; fetch is master, decode is slave.
interface inst_fetch_unit_if;
  import cpu_pkg::*;

  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_word;
  logic [INST_W-1:0] inst_pc;
  logic              inst_pred_taken;

  modport master (
    output inst_valid, inst_word, inst_pc, inst_pred_taken,
    input  inst_ready
  );

  modport slave (
    input  inst_valid, inst_word, inst_pc, inst_pred_taken,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Prefetch FIFO of {pc, word, pred_taken}; the head output holds its last value while empty.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fq_entry_t                wr_entry,
  output fq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t       mem [DEPTH];
  fq_entry_t       last_head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // NOTE: storage has no reset; count gates the head mux, so unwritten entries are never seen.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign head = (count != '0) ? mem[rd_ptr] : last_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_head <= '0;
    end else begin
      last_head <= head;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, credit-based code-memory requests, redirect flush and prefetch queue.
// Optional static predecode of unconditional B/BL under FETCH_BRANCH_PREDECODE_EN.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                QUEUE_DEPTH = 4,
  parameter logic [INST_W-1:0] RESET_PC    = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [INST_W-1:0]     imem_addr,
  input  logic [INST_W-1:0]     imem_rdata,
  input  logic                  redirect_valid,
  input  logic [INST_W-1:0]     redirect_pc,
  inst_fetch_unit_if.master     inst_if
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [INST_W-1:0] fpc;
  logic [INST_W-1:0] inflight_pc;
  logic              inflight;
  logic              issue;
  logic              push;
  logic              pop;
  logic              pd_taken;
  logic [INST_W-1:0] pd_target;
  logic [CW-1:0]     count;
  fq_entry_t         wr_entry;
  fq_entry_t         head;

  // Credit counts the queue before this cycle's pop, so a push can never find it full.
  assign issue     = !reset && !redirect_valid &&
                     ((32'(count) + 32'(inflight)) < 32'(QUEUE_DEPTH));
  assign imem_req  = issue;
  assign imem_addr = fpc;

  assign push = inflight && !redirect_valid;
  assign pop  = inst_if.inst_valid && inst_if.inst_ready;

`ifdef FETCH_BRANCH_PREDECODE_EN
  assign pd_taken  = push && is_uncond_branch(imem_rdata);
  assign pd_target = inflight_pc + 32'd8 + branch_offset(imem_rdata);
`else
  assign pd_taken  = 1'b0;
  assign pd_target = inflight_pc;
`endif

  assign wr_entry = '{pc: inflight_pc, word: imem_rdata, pred_taken: pd_taken};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc         <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fpc      <= redirect_pc & ~32'h3;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= fpc;
      // A predecoded branch retargets fetch and drops the sequential request issued alongside it.
      if (pd_taken) begin
        fpc      <= pd_target;
        inflight <= 1'b0;
      end else if (issue) begin
        fpc <= fpc + 32'd4;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

  assign inst_if.inst_valid      = (count != '0);
  assign inst_if.inst_word       = head.word;
  assign inst_if.inst_pc         = head.pc;
  assign inst_if.inst_pred_taken = head.pred_taken;

endmodule
